ps2_key_ctrl: RTL
=================

# ps2_key_ctrl

Sequencer that sits directly after the PS/2 byte receiver. It consumes the received scan-code byte stream (one-cycle `in_ready` strobes) and parses the set-2 prefixes (`E0` extended, `F0` break) into complete key events. It suppresses typematic repeats of a held key and queues events in a small FIFO for the consumer (display/ASCII stage) under a valid/ready handshake. It also maintains a press counter and the currently held key for the segment display.

## Interface
- `DEPTH`, 8: event FIFO depth, power of two, at least 2.
- `TIMEOUT`, 1_000_000: clk cycles a prefix state may wait for its next byte before it is abandoned.
- `clk  in  1`: single clock, all state on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_data  in  8`: received byte, valid only while `in_ready` is high.
- `in_ready  in  1`: one-cycle strobe, at least 2 cycles apart.
- `evt_valid  out  1`: FIFO head holds an event.
- `evt_ready  in  1`: consumer accepts the head event when `evt_valid` is also high.
- `evt_code  out  8`: head event scan code, excluding prefixes.
- `evt_ext  out  1`: head event carried an `E0` prefix.
- `evt_brk  out  1`: head event is a release (break).
- `held_valid  out  1`: a key is currently held.
- `held_code  out  8`: code of the held key.
- `held_ext  out  1`: extended flag of the held key.
- `press_cnt  out  8`: number of accepted make events, wraps 255 -> 0.
- `ovf  out  1`: sticky flag, an event was dropped because the FIFO was full.

## Operation
- Parser FSM states and transitions, taken on an `in_ready` cycle:
  - IDLE: `E0` -> EXT; `F0` -> BRK; any other byte emits a make event with ext=0 and stays in IDLE.
  - EXT: `F0` -> EXT_BRK; `E0` stays in EXT; other byte emits a make event with ext=1 -> IDLE.
  - BRK: `E0` -> EXT_BRK; `F0` stays in BRK; other byte emits a break event with ext=0 -> IDLE.
  - EXT_BRK: `E0`/`F0` stay in EXT_BRK; other byte emits a break event with ext=1 -> IDLE.
- Timeout: a counter clears on every `in_ready`. In any state other than IDLE, reaching `TIMEOUT` forces IDLE and emits nothing.
- Make handling:
  - If `held_valid` is set and {code, ext} equals {`held_code`, `held_ext`}, the make is a typematic repeat. It is dropped: no push, no count.
  - Otherwise the make is pushed, `held_*` is loaded with it, `held_valid` is set, and `press_cnt` increments.
- Break handling:
  - A break is always pushed.
  - If it matches the held key, `held_valid` clears and `held_code`/`held_ext` are left unchanged.
  - A non-matching break leaves the held state untouched.
- FIFO:
  - One event is 10 bits {brk, ext, code}, show-ahead; the head drives the `evt_*` outputs.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - A push while full with no pop drops the event and sets `ovf`. `held_*` and `press_cnt` update regardless.
  - A pop while empty is ignored.
- Reset values:
  - `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0.
  - `held_valid`=0, `held_code`=0, `held_ext`=0.
  - `press_cnt`=0, `ovf`=0, FSM=IDLE, FIFO empty, timeout counter 0.
  - Reset mid-sequence, for example after `E0 F0`, discards the partial prefix.

## Timing
- Event latency: an `in_ready` cycle whose byte completes an event pushes on that clock edge. `evt_valid` is high from the next cycle.
- Held state and `press_cnt` update on the same edge as the push.
- Pop: the head advances on the edge where `evt_valid & evt_ready`. The next entry, if any, is presented in the following cycle with no bubble.
- The consumer may hold `evt_ready` high permanently. Throughput is one event per cycle.
- `rst` overrides `in_ready` and `evt_ready` in the same cycle.

## Structure
- Shared package `ps2_pkg` holds:
  - Constants `PS2_PFX_EXT`=8'hE0 and `PS2_PFX_BRK`=8'hF0.
  - The FSM state enum.
  - The packed event struct {brk, ext, code[7:0]}.
- Sub-module `ps2_evt_fifo`: a parameterised synchronous show-ahead FIFO with push/pop/full/empty, reusable for other keyboard consumers.
- The parser, held-key tracking, counter and timeout stay in the top-level block.

## Test plan
- Bytes `1C`, `F0`, `1C` -> events {0,0,1C} then {1,0,1C}; `press_cnt`=1; `held_valid` 1 then 0.
- Bytes `1C 1C 1C F0 1C` (typematic) -> exactly two events; `press_cnt`=1.
- Bytes `E0 75 E0 F0 75` -> events {0,1,75} and {1,1,75}. Then `75` alone -> {0,0,75}, not treated as a repeat.
- `E0` followed by `TIMEOUT` idle cycles, then `1C` -> single event {0,0,1C}. Separately, `rst` after `E0 F0` then `1C` -> make {0,0,1C}.
- `evt_ready`=0 and DEPTH+1 distinct makes -> DEPTH events retained in order, `ovf`=1, `press_cnt`=DEPTH+1. Simultaneous push and pop while full -> no drop.
- 256 distinct press/release pairs -> `press_cnt` wraps to 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code sequencer and its event consumers.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } ps2_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO; push and pop may coincide even when full, pop while empty is ignored.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Parses set-2 scan-code bytes into make/break events, suppresses typematic repeats,
// tracks the held key and press count, and queues events for the consumer.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       held_valid,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [7:0] press_cnt,
    output logic       ovf
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    ps2_state_e state_q, state_d;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    logic       emit;
    logic       emit_brk;
    logic       emit_ext;
    logic       is_rpt;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    ps2_evt_t   ev_in;
    ps2_evt_t   ev_head;

    logic       held_valid_q;
    logic [7:0] held_code_q;
    logic       held_ext_q;
    logic [7:0] press_cnt_q;
    logic       ovf_q;

    // Counts cycles since the last byte; fires on the TIMEOUT-th idle cycle of a prefix state.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (in_ready) begin
            unique case (state_q)
                StIdle: begin
                    if (in_data == PS2_PFX_EXT)      state_d = StExt;
                    else if (in_data == PS2_PFX_BRK) state_d = StBrk;
                    else                             emit    = 1'b1;
                end
                StExt: begin
                    if (in_data == PS2_PFX_BRK)      state_d = StExtBrk;
                    else if (in_data != PS2_PFX_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    if (in_data == PS2_PFX_EXT)      state_d = StExtBrk;
                    else if (in_data != PS2_PFX_BRK) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StExtBrk: begin
                    if (in_data != PS2_PFX_EXT && in_data != PS2_PFX_BRK) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
            endcase
        end else if (state_q != StIdle && tmo_hit) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        ev_in.brk  = emit_brk;
        ev_in.ext  = emit_ext;
        ev_in.code = in_data;
        is_rpt     = held_valid_q && (held_code_q == in_data) && (held_ext_q == emit_ext);
        push       = emit && (emit_brk || !is_rpt);
        pop        = evt_ready && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            press_cnt_q  <= 8'h00;
            ovf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_ready || state_d == StIdle) tmo_q <= '0;
            else                               tmo_q <= tmo_q + 1'b1;

            if (push && !emit_brk) begin
                held_valid_q <= 1'b1;
                held_code_q  <= in_data;
                held_ext_q   <= emit_ext;
                press_cnt_q  <= press_cnt_q + 8'd1;
            end else if (push && emit_brk && is_rpt) begin
                held_valid_q <= 1'b0;
            end

            if (push && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(ps2_evt_t))
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(ev_in),
        .pop  (pop),
        .rdata(ev_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = ev_head.code;
    assign evt_ext    = ev_head.ext;
    assign evt_brk    = ev_head.brk;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;
    assign held_ext   = held_ext_q;
    assign press_cnt  = press_cnt_q;
    assign ovf        = ovf_q;

endmodule
